// File: rtl/mod_148_timer_bank.sv
// mod_148_timer_bank: bank of one-shot state-machine timers with fixed or
// randomised durations, counted in ticks of a shared prescaler.
//
// Ports:
//   clk            - single clock, all state updates on the rising edge
//   reset_n        - synchronous active-low reset
//   start          - per-channel start/restart strobe (wins over stop)
//   stop           - per-channel stop strobe
//   rand_en        - per-channel: 1 = duration drawn from [dur_min, dur_max]
//   dur_min        - per-channel minimum duration, channel i at [i*COUNT_W +: COUNT_W]
//   dur_max        - per-channel maximum duration, same packing
//   timer_done     - channel expired (sticky until next start/stop)
//   timer_not_done - channel running
module mod_148_timer_bank #(
    parameter int          CHANNELS  = 2,
    parameter int          COUNT_W   = 16,
    parameter int          TICK_DIV  = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS-1:0]          start,
    input  logic [CHANNELS-1:0]          stop,
    input  logic [CHANNELS-1:0]          rand_en,
    input  logic [CHANNELS*COUNT_W-1:0]  dur_min,
    input  logic [CHANNELS*COUNT_W-1:0]  dur_max,
    output logic [CHANNELS-1:0]          timer_done,
    output logic [CHANNELS-1:0]          timer_not_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXP  = 2'd2
    } state_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [15:0]        lfsr_q, lfsr_d;
    state_e             state_q [CHANNELS];
    state_e             state_d [CHANNELS];
    logic [COUNT_W-1:0] cnt_q   [CHANNELS];
    logic [COUNT_W-1:0] cnt_d   [CHANNELS];

    // Duration for one channel. The random part is folded into [0, span]:
    // r is bounded by the smeared mask (< 2*span+2), so r-span-1 <= span.
    function automatic logic [COUNT_W-1:0] calc_dur(
        input logic               ren,
        input logic [COUNT_W-1:0] mn,
        input logic [COUNT_W-1:0] mx,
        input logic [COUNT_W-1:0] rnd
    );
        logic [COUNT_W-1:0] span;
        logic [COUNT_W-1:0] mask;
        logic [COUNT_W-1:0] r;
        logic [COUNT_W-1:0] m;
        span = mx - mn;
        mask = span;
        for (int i = 0; i < COUNT_W; i++) begin
            mask = mask | (mask >> 1);
        end
        r = rnd & mask;
        m = (r <= span) ? r : (r - span - 1'b1);
        calc_dur = (ren && (mx > mn)) ? (mn + m) : mn;
    endfunction

    // Shared prescaler and LFSR (LFSR advances every clock, not per tick).
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        lfsr_d  = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
            lfsr_q  <= LFSR_SEED;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
            end
        end else begin
            presc_q <= presc_d;
            lfsr_q  <= lfsr_d;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    // Next-state logic
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            if (start[c]) begin
                state_d[c] = ST_RUN;
                cnt_d[c]   = calc_dur(rand_en[c],
                                      dur_min[c*COUNT_W +: COUNT_W],
                                      dur_max[c*COUNT_W +: COUNT_W],
                                      lfsr_q[COUNT_W-1:0]);
            end else if (stop[c]) begin
                state_d[c] = ST_IDLE;
                cnt_d[c]   = '0;
            end else if (state_q[c] == ST_RUN) begin
                if (cnt_q[c] == '0) begin
                    state_d[c] = ST_EXP;
                end else if (tick) begin
                    cnt_d[c] = cnt_q[c] - 1'b1;
                end
            end
        end
    end

    // Output decode, registered state only
    always_comb begin
        timer_done     = '0;
        timer_not_done = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            timer_done[c]     = (state_q[c] == ST_EXP);
            timer_not_done[c] = (state_q[c] == ST_RUN);
        end
    end

endmodule

// File: tb/tb_mod_148_timer_bank.sv
// tb_mod_148_timer_bank: self-checking bench for mod_148_timer_bank.
// Table vectors, scoreboard of expected run lengths, LFSR reference model.
module tb_mod_148_timer_bank;

    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  start = '0, stop = '0, rand_en = '0;
    logic [1:0]  start4 = '0, stop4 = '0;
    logic [31:0] dur_min = '0, dur_max = '0;
    logic [1:0]  done, nd, done4, nd4;

    always #5 clk = ~clk;

    mod_148_timer_bank #(
        .CHANNELS(2), .COUNT_W(16), .TICK_DIV(1), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .rand_en(rand_en), .dur_min(dur_min), .dur_max(dur_max),
        .timer_done(done), .timer_not_done(nd)
    );

    mod_148_timer_bank #(
        .CHANNELS(2), .COUNT_W(16), .TICK_DIV(4), .LFSR_SEED(16'hACE1)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .stop(stop4),
        .rand_en(rand_en), .dur_min(dur_min), .dur_max(dur_max),
        .timer_done(done4), .timer_not_done(nd4)
    );

    // Reference LFSR and prescaler phase
    logic [15:0] m_lfsr;
    int          m_ph;
    always @(posedge clk) begin
        if (!reset_n) begin
            m_lfsr <= 16'hACE1;
            m_ph   <= 0;
        end else begin
            m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            m_ph   <= (m_ph + 1) % 4;
        end
    end

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    typedef struct {
        int ch;
        bit ren;
        int mn;
        int mx;
        int d;
    } vec_t;
    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_dur(input bit ren, input int mn,
                                     input int mx, input logic [15:0] lf);
        int span, mask, r, m;
        if (!ren || mx <= mn) return mn;
        span = mx - mn;
        mask = (1 << $clog2(span + 1)) - 1;
        r = int'(lf) & mask;
        m = (r <= span) ? r : r - span - 1;
        return mn + m;
    endfunction

    function automatic bit ndv(input bit w4, input int ch);
        return w4 ? nd4[ch] : nd[ch];
    endfunction

    function automatic bit donev(input bit w4, input int ch);
        return w4 ? done4[ch] : done[ch];
    endfunction

    task automatic set_ch(input int ch, input bit ren, input int mn,
                          input int mx);
        rand_en[ch] = ren;
        dur_min[ch*16 +: 16] = 16'(mn);
        dur_max[ch*16 +: 16] = 16'(mx);
    endtask

    task automatic pulse(input bit w4, input logic [1:0] s,
                         input logic [1:0] p);
        if (w4) begin
            start4 = s;
            stop4 = p;
        end else begin
            start = s;
            stop = p;
        end
        step();
        start = '0;
        stop = '0;
        start4 = '0;
        stop4 = '0;
    endtask

    task automatic measure(input bit w4, input int ch, output int len);
        len = 0;
        while (ndv(w4, ch) && len < LIMIT) begin
            len++;
            step();
        end
    endtask

    task automatic score(input string name, input int act);
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk(name, act, e);
    endtask

    task automatic run_vec(input string name, input bit w4, input int ch,
                           input int exp_len, output int len);
        exp_q.push_back(exp_len);
        pulse(w4, 2'(1 << ch), 2'b00);
        measure(w4, ch, len);
        score(name, len);
        chk({name, "_done"}, int'(donev(w4, ch)), 1);
    endtask

    initial begin
        int len, cnt, d, d0;
        bit seen;
        int ph_exp[4];

        tbl[0] = '{0, 1'b0, 5, 0, 5};
        tbl[1] = '{1, 1'b0, 0, 0, 0};
        tbl[2] = '{0, 1'b1, 7, 7, 7};
        tbl[3] = '{0, 1'b1, 9, 3, 9};
        tbl[4] = '{1, 1'b0, 2, 0, 2};
        tbl[5] = '{1, 1'b1, 12, 12, 12};
        tbl[6] = '{0, 1'b0, 1, 100, 1};
        tbl[7] = '{1, 1'b1, 0, 0, 0};
        ph_exp = '{12, 11, 10, 13};

        // Reset dominates start
        reset_n = 1'b0;
        start = 2'b11;
        start4 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outs", int'({done, nd, done4, nd4}), 0);
        end
        start = '0;
        start4 = '0;
        reset_n = 1'b1;
        step();

        // Fixed duration and sticky done
        set_ch(0, 1'b0, 5, 0);
        run_vec("fixed5", 1'b0, 0, 6, len);
        cnt = 0;
        repeat (20) begin
            if (done[0] && !nd[0]) cnt++;
            step();
        end
        chk("done_hold20", cnt, 20);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            set_ch(tbl[i].ch, tbl[i].ren, tbl[i].mn, tbl[i].mx);
            run_vec($sformatf("vec%0d", i), 1'b0, tbl[i].ch,
                    tbl[i].d + 1, len);
        end

        // Restart 4 clocks after start reloads the count
        set_ch(0, 1'b0, 10, 0);
        pulse(1'b0, 2'b01, 2'b00);
        repeat (3) step();
        chk("restart_running", int'(nd[0]), 1);
        exp_q.push_back(15);
        pulse(1'b0, 2'b01, 2'b00);
        measure(1'b0, 0, len);
        score("restart_total", len + 4);

        // Stop after 3 clocks
        set_ch(1, 1'b0, 10, 0);
        pulse(1'b0, 2'b10, 2'b00);
        step();
        step();
        pulse(1'b0, 2'b00, 2'b10);
        chk("stop_outs", int'({done[1], nd[1]}), 0);
        seen = 1'b0;
        repeat (20) begin
            step();
            if (done[1] || nd[1]) seen = 1'b1;
        end
        chk("stop_no_done", int'(seen), 0);

        // Start wins over stop
        pulse(1'b0, 2'b10, 2'b10);
        chk("start_stop_run", int'({done[1], nd[1]}), 1);
        pulse(1'b0, 2'b00, 2'b10);
        chk("stop_idle", int'({done[1], nd[1]}), 0);

        // Prescaler phases with TICK_DIV=4, D=3
        set_ch(0, 1'b0, 3, 0);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 8 && m_ph != p; k++) step();
            run_vec($sformatf("presc_ph%0d", p), 1'b1, 0, ph_exp[p], len);
        end

        // Random range with no folding needed
        set_ch(0, 1'b1, 40, 295);
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) step();
            d = model_dur(1'b1, 40, 295, m_lfsr);
            run_vec("rand_wide", 1'b0, 0, d + 1, len);
            chk("rand_range", int'(len >= 41 && len <= 296), 1);
        end

        // Random range exercising the fold branch
        set_ch(0, 1'b1, 10, 15);
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) step();
            d = model_dur(1'b1, 10, 15, m_lfsr);
            run_vec("rand_fold", 1'b0, 0, d + 1, len);
        end

        // Channel independence, then reset mid-count
        set_ch(0, 1'b0, 100, 0);
        set_ch(1, 1'b0, 2, 0);
        exp_q.push_back(3);
        pulse(1'b0, 2'b11, 2'b00);
        measure(1'b0, 1, len);
        score("indep_ch1", len);
        chk("indep_ch0_run", int'({done[0], nd[0]}), 1);
        repeat (47) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midreset_outs", int'({done, nd}), 0);
        seen = 1'b0;
        repeat (120) begin
            step();
            if (done != 2'b00 || nd != 2'b00) seen = 1'b1;
        end
        chk("no_late_expiry", int'(seen), 0);

        // Post-reset LFSR sequence is reproducible
        set_ch(0, 1'b1, 40, 295);
        d0 = 0;
        for (int k = 0; k < 2; k++) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            repeat (5) step();
            d = model_dur(1'b1, 40, 295, m_lfsr);
            if (k == 0) d0 = d;
            run_vec($sformatf("post_reset%0d", k), 1'b0, 0, d + 1, len);
            chk($sformatf("repro%0d", k), len - 1, d0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
